// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR controller: one shared multiply-accumulate walks TAPS taps per sample,
// with a sample delay line, a writable coefficient bank and valid/ready on both streams.
module fir_mac_scheduler #(
    parameter int unsigned          N        = 32,
    parameter int unsigned          CW       = 8,
    parameter int unsigned          TAPS     = 4,
    parameter logic        [CW-1:0] COEF_RST = 8'h20
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_coef_wr_en,
    input  logic [$clog2(TAPS)-1:0] i_coef_wr_addr,
    input  logic [CW-1:0]           i_coef_wr_data,
    output logic                    o_coef_wr_ready,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [N-1:0]            i_in_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [N-1:0]            o_out_data,
    output logic                    o_busy
);

    localparam int unsigned IW = $clog2(TAPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_x    [TAPS];
    logic [CW-1:0]   r_coef [TAPS];
    logic [N-1:0]    r_acc;
    logic [IW-1:0]   r_idx;
    logic            r_out_valid;
    logic [N-1:0]    r_out_data;

    logic            w_accept;
    logic            w_coef_wr;
    logic            w_last;
    logic [N-1:0]    w_prod;
    logic [N-1:0]    w_sum;

    // Both ready signals drop immediately while reset is held, not just after the edge.
    assign o_in_ready      = (r_state == S_IDLE) && !i_reset;
    assign o_coef_wr_ready = (r_state == S_IDLE) && !i_reset;
    assign o_busy          = (r_state != S_IDLE);
    assign o_out_valid     = r_out_valid;
    assign o_out_data      = r_out_data;

    assign w_accept  = i_in_valid && o_in_ready;
    assign w_coef_wr = i_coef_wr_en && o_coef_wr_ready;
    assign w_last    = (r_idx == IW'(TAPS - 1));
    // Multiplying in N-bit context keeps only the low N bits of the product.
    assign w_prod    = r_x[r_idx] * {{(N - CW){1'b0}}, r_coef[r_idx]};
    assign w_sum     = r_acc + w_prod;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_MAC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MAC: begin
                if (w_last) begin
                    w_state_nxt = S_OUT;
                end else begin
                    w_state_nxt = S_MAC;
                end
            end
            S_OUT: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Coefficient bank: writes only land while idle; out-of-range tap indices are dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= COEF_RST;
            end
        end else if (w_coef_wr && (int'(i_coef_wr_addr) < TAPS)) begin
            r_coef[i_coef_wr_addr] <= i_coef_wr_data;
        end else begin
            r_coef <= r_coef;
        end
    end

    // Delay line, accumulator, tap walk and registered result.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= {N{1'b0}};
            end
            r_acc       <= {N{1'b0}};
            r_idx       <= {IW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_data  <= {N{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x[0] <= i_in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_acc <= {N{1'b0}};
                        r_idx <= {IW{1'b0}};
                    end
                end
                S_MAC: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_idx       <= {IW{1'b0}};
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sum;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Randomised bench for fir_mac_scheduler against a sum-of-products reference model of the FIR.
module tb_fir_mac_scheduler;

    localparam int TAPS = 4;

    logic        clk;
    logic        reset;
    logic        coef_wr_en;
    logic [1:0]  coef_wr_addr;
    logic [7:0]  coef_wr_data;
    logic        coef_wr_ready;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_checks;
    int n_errors;

    logic [31:0] hist  [TAPS];
    logic [7:0]  mcoef [TAPS];

    fir_mac_scheduler dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_coef_wr_en   (coef_wr_en),
        .i_coef_wr_addr (coef_wr_addr),
        .i_coef_wr_data (coef_wr_data),
        .o_coef_wr_ready(coef_wr_ready),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_data      (in_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_data     (out_data),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_y();
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < TAPS; k++) begin
            s = s + hist[k] * {24'd0, mcoef[k]};
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            hist[k]  = 32'd0;
            mcoef[k] = 8'h20;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; coef_wr_en = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 32'd0);
        check_eq("rst_wr_ready", coef_wr_ready, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_busy", busy, 32'd0);
        check_eq("rst_idle_ready", in_ready, 32'd1);
        model_reset();
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        check_eq("wr_ready_idle", coef_wr_ready, 32'd1);
        coef_wr_en = 1'b1; coef_wr_addr = a; coef_wr_data = d;
        @(posedge clk);
        mcoef[a] = d;
        @(negedge clk);
        coef_wr_en = 1'b0;
    endtask

    // One sample through the block with optional same-cycle write, dropped write in MAC and stall.
    task automatic send(input logic [31:0] x, input int stall, input bit wr_same, input bit wr_mac);
        int k;
        bit got;
        logic [31:0] exp;
        logic [1:0] a;
        logic [7:0] d;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("in_ready_idle", in_ready, 32'd1);
        in_valid = 1'b1; in_data = x;
        a = 2'($urandom_range(0, 3)); d = 8'($urandom);
        if (wr_same) begin
            coef_wr_en = 1'b1; coef_wr_addr = a; coef_wr_data = d;
        end
        @(posedge clk);
        if (wr_same) mcoef[a] = d;
        for (int j = TAPS - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = x;
        exp = model_y();
        @(negedge clk);
        coef_wr_en = 1'b0;
        in_valid = 1'($urandom_range(0, 1)); in_data = $urandom;
        if (wr_mac) begin
            coef_wr_en = 1'b1; coef_wr_addr = 2'd0; coef_wr_data = 8'd0;
            check_eq("wr_ready_mac", coef_wr_ready, 32'd0);
        end
        k = 1; got = 1'b0;
        while (k <= 20) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            check_eq("in_ready_mac", in_ready, 32'd0);
            check_eq("busy_mac", busy, 32'd1);
            @(negedge clk);
            coef_wr_en = 1'b0;
            in_valid = 1'($urandom_range(0, 1)); in_data = $urandom;
            k++;
        end
        coef_wr_en = 1'b0;
        check_eq("out_valid_seen", 32'(got), 32'd1);
        check_eq("latency_cycles", k, TAPS + 1);
        for (int s = 0; s < stall; s++) begin
            check_eq("stall_valid", out_valid, 32'd1);
            check_eq("stall_data", out_data, exp);
            check_eq("stall_in_ready", in_ready, 32'd0);
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1)); in_data = $urandom;
        end
        check_eq("out_data", out_data, exp);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        check_eq("post_hs_valid", out_valid, 32'd0);
        check_eq("post_hs_busy", busy, 32'd0);
        check_eq("post_hs_retain", out_data, exp);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b1; coef_wr_en = 1'b0; coef_wr_addr = 2'd0; coef_wr_data = 8'd0;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        model_reset();
        do_reset();

        // Default moving-average coefficients.
        send(32'd4, 0, 1'b0, 1'b0);
        send(32'd8, 0, 1'b0, 1'b0);
        send(32'd12, 0, 1'b0, 1'b0);
        send(32'd16, 0, 1'b0, 1'b0);

        // Impulse response through loaded coefficients, plus a write dropped during MAC.
        write_coef(2'd0, 8'd1); write_coef(2'd1, 8'd2);
        write_coef(2'd2, 8'd3); write_coef(2'd3, 8'd4);
        send(32'd1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send(32'd0, 0, 1'b0, 1'b0);
        send(32'd1, 5, 1'b0, 1'b0);
        send(32'd7, 2, 1'b0, 1'b0);

        // Modular wrap with maximal coefficients.
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(2'(i), 8'hFF);
        send(32'hFFFF_FFFF, 0, 1'b0, 1'b0);

        // Reset during the second MAC cycle aborts the sample.
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd99;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_in_ready", in_ready, 32'd0);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("abort_no_valid", out_valid, 32'd0);
        end
        send(32'd4, 0, 1'b0, 1'b0);

        // Random traffic with coefficient updates.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) write_coef(2'($urandom_range(0, 3)), 8'($urandom));
            send($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
